// File: rtl/seg7_frame_decoder.sv
// Seven-segment frame decoder: snapshots NUM_DIGITS segment patterns on START
// and decodes one digit per clock, most significant first, into a packed hex
// value with per-digit error and blank flags.
module seg7_frame_decoder #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [7*NUM_DIGITS-1:0]   HEX_IN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [4*NUM_DIGITS-1:0]   VALUE,
  output logic [NUM_DIGITS-1:0]     ERR_MASK,
  output logic [NUM_DIGITS-1:0]     BLANK_MASK
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                    state_q, state_d;
  logic [7*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   acc_q, acc_d;
  logic [NUM_DIGITS-1:0]     err_w_q, err_w_d;
  logic [NUM_DIGITS-1:0]     blank_w_q, blank_w_d;
  logic [4*NUM_DIGITS-1:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]     err_mask_q, err_mask_d;
  logic [NUM_DIGITS-1:0]     blank_mask_q, blank_mask_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [6:0]                cur_code;
  logic [5:0]                dec;

  // Returns {blank, err, nibble} for an active-low g..a code.
  function automatic logic [5:0] decode_seg(input logic [6:0] code);
    case (code)
      7'h40:   decode_seg = {2'b00, 4'h0};
      7'h79:   decode_seg = {2'b00, 4'h1};
      7'h24:   decode_seg = {2'b00, 4'h2};
      7'h30:   decode_seg = {2'b00, 4'h3};
      7'h19:   decode_seg = {2'b00, 4'h4};
      7'h12:   decode_seg = {2'b00, 4'h5};
      7'h02:   decode_seg = {2'b00, 4'h6};
      7'h78:   decode_seg = {2'b00, 4'h7};
      7'h00:   decode_seg = {2'b00, 4'h8};
      7'h10:   decode_seg = {2'b00, 4'h9};
      7'h08:   decode_seg = {2'b00, 4'hA};
      7'h03:   decode_seg = {2'b00, 4'hB};
      7'h46:   decode_seg = {2'b00, 4'hC};
      7'h21:   decode_seg = {2'b00, 4'hD};
      7'h06:   decode_seg = {2'b00, 4'hE};
      7'h0E:   decode_seg = {2'b00, 4'hF};
      7'h7F:   decode_seg = {2'b10, 4'h0};
      default: decode_seg = {2'b01, 4'h0};
    endcase
  endfunction

  // Next-state logic: capture on START from idle, then one digit per clock.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    err_w_d      = err_w_q;
    blank_w_d    = blank_w_q;
    value_d      = value_q;
    err_mask_d   = err_mask_q;
    blank_mask_d = blank_mask_q;

    cur_code = shadow_q[7*idx_q +: 7];
    if (!ACTIVE_LOW) begin
      cur_code = ~cur_code;
    end
    dec = decode_seg(cur_code);

    case (state_q)
      StIdle: begin
        if (START) begin
          shadow_d  = HEX_IN;
          idx_d     = IdxW'(NUM_DIGITS - 1);
          acc_d     = '0;
          err_w_d   = '0;
          blank_w_d = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        acc_d          = acc_q << 4;
        acc_d[3:0]     = dec[3:0];
        err_w_d[idx_q]   = dec[4];
        blank_w_d[idx_q] = dec[5];
        if (idx_q == '0) begin
          // Publish the completed frame on the same edge that enters DONE.
          value_d      = acc_d;
          err_mask_d   = err_w_d;
          blank_mask_d = blank_w_d;
          state_d      = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      err_w_q      <= '0;
      blank_w_q    <= '0;
      value_q      <= '0;
      err_mask_q   <= '0;
      blank_mask_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      err_w_q      <= err_w_d;
      blank_w_q    <= blank_w_d;
      value_q      <= value_d;
      err_mask_q   <= err_mask_d;
      blank_mask_q <= blank_mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign VALUE      = value_q;
  assign ERR_MASK   = err_mask_q;
  assign BLANK_MASK = blank_mask_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: a 6-digit active-low instance driven
// from a vector table plus hand-written corner sequences, and a 2-digit
// active-high instance.
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_m, start_s;
  logic [41:0] hex_m;
  logic [13:0] hex_s;
  logic        busy_m, done_m, busy_s, done_s;
  logic [23:0] value_m;
  logic [5:0]  err_m, blank_m;
  logic [7:0]  value_s;
  logic [1:0]  err_s, blank_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] last_val = '0;
  logic [7:0]  last_val_s = '0;

  always #5 clk = ~clk;

  seg7_frame_decoder #(.NUM_DIGITS(6), .ACTIVE_LOW(1'b1)) u_main (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .START      (start_m),
    .HEX_IN     (hex_m),
    .BUSY       (busy_m),
    .DONE       (done_m),
    .VALUE      (value_m),
    .ERR_MASK   (err_m),
    .BLANK_MASK (blank_m)
  );

  seg7_frame_decoder #(.NUM_DIGITS(2), .ACTIVE_LOW(1'b0)) u_small (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .START      (start_s),
    .HEX_IN     (hex_s),
    .BUSY       (busy_s),
    .DONE       (done_s),
    .VALUE      (value_s),
    .ERR_MASK   (err_s),
    .BLANK_MASK (blank_s)
  );

  typedef struct {
    logic [41:0] hex;
    logic [23:0] val;
    logic [5:0]  err;
    logic [5:0]  blank;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] f6(input logic [6:0] h5, input logic [6:0] h4,
                                     input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  // Runs one frame on the 6-digit instance and checks latency, busy length,
  // output hold during the scan and the published result.
  task automatic run_main(input logic [41:0] hx, input bit chg, input logic [41:0] hx2,
                          input logic [23:0] ev, input logic [5:0] ee,
                          input logic [5:0] eb, input string nm);
    int lat, busy_cnt, dones;
    bit held;
    hex_m   = hx;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    if (chg) hex_m = hx2;
    lat      = 0;
    busy_cnt = busy_m ? 1 : 0;
    dones    = 0;
    held     = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy_m) busy_cnt++;
      if (done_m) begin
        dones++;
        if (lat == 0) lat = i;
      end
      if (i < 6 && value_m !== last_val) held = 1'b0;
    end
    check({nm, " latency"}, lat, 6);
    check({nm, " done_pulses"}, dones, 1);
    check({nm, " busy_cycles"}, busy_cnt, 7);
    check({nm, " value_held"}, held, 1);
    check({nm, " value"}, value_m, ev);
    check({nm, " err"}, err_m, ee);
    check({nm, " blank"}, blank_m, eb);
    last_val = ev;
  endtask

  task automatic run_small(input logic [13:0] hx, input logic [7:0] ev,
                           input logic [1:0] ee, input logic [1:0] eb, input string nm);
    int lat, dones;
    hex_s   = hx;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    lat     = 0;
    dones   = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (done_s) begin
        dones++;
        if (lat == 0) lat = i;
      end
    end
    check({nm, " latency"}, lat, 2);
    check({nm, " done_pulses"}, dones, 1);
    check({nm, " value"}, value_s, ev);
    check({nm, " err"}, err_s, ee);
    check({nm, " blank"}, blank_s, eb);
    last_val_s = ev;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{f6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02), 24'h123456, 6'b000000, 6'b000000};
    vecs[1] = '{f6(7'h0E, 7'h21, 7'h46, 7'h03, 7'h08, 7'h00), 24'hFDCBA8, 6'b000000, 6'b000000};
    vecs[2] = '{f6(7'h7F, 7'h7F, 7'h55, 7'h40, 7'h40, 7'h40), 24'h000000, 6'b001000, 6'b110000};
    vecs[3] = '{f6(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12), 24'h012345, 6'b000000, 6'b000000};
    vecs[4] = '{f6(7'h02, 7'h78, 7'h00, 7'h10, 7'h40, 7'h79), 24'h678901, 6'b000000, 6'b000000};
    vecs[5] = '{f6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F), 24'h000000, 6'b000000, 6'b111111};

    rst     = 1'b1;
    start_m = 1'b0;
    start_s = 1'b0;
    hex_m   = '1;
    hex_s   = '0;
    tick();
    tick();
    check("reset busy", busy_m, 0);
    check("reset done", done_m, 0);
    check("reset value", value_m, 0);
    check("reset err", err_m, 0);
    check("reset blank", blank_m, 0);
    check("reset small value", value_s, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      run_main(vecs[k].hex, 1'b0, '0, vecs[k].val, vecs[k].err, vecs[k].blank,
               $sformatf("vec%0d", k));
    end

    // Inputs change right after capture; result must reflect the snapshot.
    run_main(vecs[1].hex, 1'b1, f6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40),
             24'hFDCBA8, 6'b0, 6'b0, "snapshot");

    // Second START two cycles into the scan must be ignored.
    hex_m   = vecs[0].hex;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    tick();
    hex_m   = vecs[4].hex;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_m) cnt++;
      tick();
    end
    check("restart done_pulses", cnt, 1);
    check("restart value", value_m, 24'h123456);
    check("restart idle", busy_m, 0);
    last_val = 24'h123456;
    run_main(vecs[4].hex, 1'b0, '0, 24'h678901, 6'b0, 6'b0, "after_restart");

    // START during the DONE cycle must not start a new frame.
    hex_m   = vecs[3].hex;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("done_start done", done_m, 1);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("done_start idle0", busy_m, 0);
    tick();
    check("done_start idle1", busy_m, 0);
    check("done_start value", value_m, 24'h012345);
    last_val = 24'h012345;

    // Reset mid-scan together with START: abort, clear, and drop START.
    hex_m   = vecs[1].hex;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    tick();
    tick();
    rst     = 1'b1;
    start_m = 1'b1;
    tick();
    rst     = 1'b0;
    start_m = 1'b0;
    check("abort busy", busy_m, 0);
    check("abort done", done_m, 0);
    check("abort value", value_m, 0);
    check("abort err", err_m, 0);
    check("abort blank", blank_m, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_m || done_m) cnt++;
      tick();
    end
    check("abort quiet", cnt, 0);
    last_val = '0;
    run_main(f6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 1'b0, '0,
             24'h000000, 6'b0, 6'b0, "post_abort");

    // Active-high instance: digits are inverted before lookup.
    run_small({7'h06, 7'h5B}, 8'h12, 2'b00, 2'b00, "small12");
    run_small({7'h00, 7'h3F}, 8'h00, 2'b00, 2'b10, "small_blank");
    run_small({7'h7F, 7'h55}, 8'h80, 2'b01, 2'b00, "small_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
